// File: rtl/gf12_pad_pkg.sv
// Shared definitions for the GF12 bidirectional pad group controller:
// link states, pad drive-strength codes and the captured pad config.
package gf12_pad_pkg;

  typedef enum logic [1:0] {
    RX      = 2'd0,
    TURN_TX = 2'd1,
    TX      = 2'd2,
    TURN_RX = 2'd3
  } pad_state_t;

  localparam logic [1:0] DS_2MA = 2'b00;
  localparam logic [1:0] DS_4MA = 2'b01;
  localparam logic [1:0] DS_6MA = 2'b10;
  localparam logic [1:0] DS_8MA = 2'b11;

  typedef struct packed {
    logic [1:0] ds;   // {DS1,DS0}
    logic       sr;
  } pad_cfg_t;

endpackage

// File: rtl/gf12_pad_in_sync.sv
// WIDTH x STAGES synchroniser for asynchronous pad Y, with a valid bit that
// travels alongside the data so the output is flagged only once fully flushed.
module gf12_pad_in_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             vld
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;
  logic [STAGES-1:0]            vld_pipe;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q   <= '0;
      vld_pipe <= '0;
    end else if (clr) begin
      sync_q   <= '0;
      vld_pipe <= '0;
    end else if (en) begin
      sync_q   <= {sync_q[STAGES-2:0], d};
      vld_pipe <= {vld_pipe[STAGES-2:0], 1'b1};
    end
  end

  assign q   = sync_q[STAGES-1];
  assign vld = vld_pipe[STAGES-1];

endmodule

// File: rtl/gf12_bidir_pad_ctrl.sv
// Core-side controller for a half-duplex GF12 pad group: direction FSM with
// guarded dead-cycle turnaround, TX word register, pad config capture, RX sync.
module gf12_bidir_pad_ctrl #(
  parameter int WIDTH       = 8,
  parameter int TURN_CYCLES = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             dir_req,
  input  logic             tx_valid,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_ready,
  output logic             rx_valid,
  output logic [WIDTH-1:0] rx_data,
  output logic             busy,
  input  logic [1:0]       cfg_ds,
  input  logic             cfg_sr,
  output logic [WIDTH-1:0] pad_a,
  output logic             pad_oe,
  output logic             pad_ie,
  output logic             pad_ds0,
  output logic             pad_ds1,
  output logic             pad_sr,
  input  logic [WIDTH-1:0] pad_y
);
  import gf12_pad_pkg::*;

  localparam int            CW       = $clog2(TURN_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(TURN_CYCLES - 1);

  pad_state_t    state;
  logic [CW-1:0] cnt;
  pad_cfg_t      cfg_q;
  logic          sync_en;

  // Sampling only while IE is already high keeps the first synchronised
  // word from ever reflecting a pad that was not yet enabled.
  assign sync_en  = (state == RX) && pad_ie && !dir_req;
  // Dropping dir_req must stall the handshake in the same cycle.
  assign tx_ready = pad_oe & dir_req;
  assign {pad_ds1, pad_ds0} = cfg_q.ds;
  assign pad_sr   = cfg_q.sr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= RX;
      cnt    <= '0;
      pad_oe <= 1'b0;
      pad_ie <= 1'b0;
      busy   <= 1'b0;
      pad_a  <= '0;
      cfg_q  <= '{ds: DS_2MA, sr: 1'b0};
    end else begin
      case (state)
        RX: begin
          if (dir_req) begin
            state  <= TURN_TX;
            pad_ie <= 1'b0;
            busy   <= 1'b1;
            cnt    <= CNT_LOAD;
            cfg_q  <= '{ds: cfg_ds, sr: cfg_sr};
          end else begin
            pad_ie <= 1'b1;
          end
        end
        TURN_TX: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (dir_req) begin
            state  <= TX;
            pad_oe <= 1'b1;
            busy   <= 1'b0;
          end else begin
            // Request withdrawn mid-turn: go straight back without touching OE.
            state <= TURN_RX;
            cnt   <= CNT_LOAD;
            cfg_q <= '{ds: cfg_ds, sr: cfg_sr};
            pad_a <= '0;
          end
        end
        TX: begin
          if (!dir_req) begin
            state  <= TURN_RX;
            pad_oe <= 1'b0;
            busy   <= 1'b1;
            cnt    <= CNT_LOAD;
            cfg_q  <= '{ds: cfg_ds, sr: cfg_sr};
            pad_a  <= '0;
          end else if (tx_valid) begin
            pad_a <= tx_data;
          end
        end
        TURN_RX: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            state  <= RX;
            pad_ie <= 1'b1;
            busy   <= 1'b0;
          end
        end
        default: state <= RX;
      endcase
    end
  end

  gf12_pad_in_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .en   (sync_en),
    .clr  (!sync_en),
    .d    (pad_y),
    .q    (rx_data),
    .vld  (rx_valid)
  );

endmodule

// File: tb/tb_gf12_bidir_pad_ctrl.sv
// Scenario bench for gf12_bidir_pad_ctrl against a link-level reference model
// tracking direction, remaining dead cycles and the recent pad Y history.
module tb_gf12_bidir_pad_ctrl;
  localparam int W = 8, TURN = 2, SYNC = 2;

  logic         clk = 1'b0, rstn = 1'b0;
  logic         dir_req = 1'b0, tx_valid = 1'b0, cfg_sr = 1'b0;
  logic [W-1:0] tx_data = '0, pad_y = '0;
  logic [1:0]   cfg_ds = '0;
  logic         tx_ready, rx_valid, busy, pad_oe, pad_ie, pad_ds0, pad_ds1, pad_sr;
  logic [W-1:0] rx_data, pad_a;

  int errors = 0, checks = 0;

  gf12_bidir_pad_ctrl #(.WIDTH(W), .TURN_CYCLES(TURN), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rstn(rstn), .dir_req(dir_req), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy),
    .cfg_ds(cfg_ds), .cfg_sr(cfg_sr), .pad_a(pad_a), .pad_oe(pad_oe), .pad_ie(pad_ie),
    .pad_ds0(pad_ds0), .pad_ds1(pad_ds1), .pad_sr(pad_sr), .pad_y(pad_y)
  );

  always #5 clk = ~clk;

  wire [22:0] obs = {pad_oe, pad_ie, busy, rx_valid, rx_data, pad_a, pad_ds1, pad_ds0, pad_sr};

  // Reference model: link side, dead cycles left, and pad Y words seen while listening.
  bit          m_oe, m_ie, m_to_tx;
  int          m_dead, m_age;
  logic [W-1:0] m_a;
  logic [2:0]  m_cfg;
  logic [W-1:0] yq[$];

  function automatic void model_reset();
    m_oe = 0; m_ie = 0; m_to_tx = 0; m_dead = 0; m_age = 0;
    m_a = '0; m_cfg = '0; yq.delete();
  endfunction

  function automatic void start_turn();
    m_dead = TURN; m_cfg = {cfg_ds, cfg_sr}; m_a = '0;
  endfunction

  function automatic void model_step();
    bit listening;
    listening = !m_oe && m_dead == 0 && m_ie && !dir_req;
    if (listening) begin
      m_age++; yq.push_back(pad_y);
      if (yq.size() > SYNC) void'(yq.pop_front());
    end else begin
      m_age = 0; yq.delete();
    end
    if (m_dead > 0) begin
      m_dead--;
      if (m_dead == 0) begin
        if (m_to_tx && dir_req) m_oe = 1;
        else if (m_to_tx) begin m_to_tx = 0; start_turn(); end
        else m_ie = 1;
      end
    end else if (m_oe) begin
      if (!dir_req) begin m_oe = 0; m_to_tx = 0; start_turn(); end
      else if (tx_valid) m_a = tx_data;
    end else if (dir_req) begin
      m_ie = 0; m_to_tx = 1; start_turn();
    end else m_ie = 1;
  endfunction

  function automatic logic [22:0] exp_vec();
    logic rv; logic [W-1:0] rd;
    rv = (m_age >= SYNC);
    rd = rv ? yq[0] : '0;
    return {m_oe, m_ie, (m_dead > 0), rv, rd, m_a, m_cfg};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  always @(negedge clk) begin
    checks++;
    if (pad_oe && pad_ie) begin
      errors++; $display("FAIL oe_ie_overlap oe=%b ie=%b required not both 1", pad_oe, pad_ie);
    end
  end

  logic [2:0] cfg_at_turn;

  task automatic test_reset();
    rstn = 0; dir_req = 0; tx_valid = 0; pad_y = 8'hA5; cfg_ds = 2'b11; cfg_sr = 1;
    model_reset();
    #3;
    checks++; if (obs !== '0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", obs); end
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL reset_tx_ready got=%b exp=0", tx_ready); end
    @(negedge clk); rstn = 1;
    tick();
    checks++; if (pad_ie !== 1'b1 || pad_oe !== 1'b0) begin errors++; $display("FAIL ie_cycle1 ie=%b oe=%b exp ie=1 oe=0", pad_ie, pad_oe); end
    tick();
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rx_valid_early got=%b exp=0", rx_valid); end
    tick();
    checks++; if (rx_valid !== 1'b1 || rx_data !== 8'hA5) begin errors++; $display("FAIL rx_first got v=%b d=%h exp v=1 d=a5", rx_valid, rx_data); end
    checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL reset_model got=%h exp=%h", obs, exp_vec()); end
  endtask

  task automatic test_rx_stream();
    for (int i = 0; i < 12; i++) begin
      pad_y = W'($urandom);
      tick();
      checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL rx_stream[%0d] got=%h exp=%h", i, obs, exp_vec()); end
    end
  endtask

  task automatic test_turn_tx();
    int busy_n = 0;
    dir_req = 1; cfg_ds = 2'($urandom); cfg_sr = 1'($urandom);
    cfg_at_turn = {cfg_ds, cfg_sr};
    for (int i = 0; i < 8 && pad_oe !== 1'b1; i++) begin
      tick();
      if (busy === 1'b1) busy_n++;
      checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL turn_tx[%0d] got=%h exp=%h", i, obs, exp_vec()); end
    end
    checks++; if (pad_oe !== 1'b1 || busy_n != TURN) begin errors++; $display("FAIL turn_tx_len oe=%b busy_cycles=%0d exp oe=1 busy=%0d", pad_oe, busy_n, TURN); end
    checks++; if ({pad_ds1, pad_ds0, pad_sr} !== cfg_at_turn) begin errors++; $display("FAIL cfg_capture got=%b exp=%b", {pad_ds1, pad_ds0, pad_sr}, cfg_at_turn); end
  endtask

  task automatic test_tx_stream();
    logic [W-1:0] words[4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    int gaps[4] = '{0, 2, 1, 3};
    cfg_ds = 2'b10; cfg_sr = ~cfg_at_turn[0];
    for (int k = 0; k < 4; k++) begin
      tx_valid = 0; tx_data = 8'hEE;
      for (int g = 0; g < gaps[k]; g++) begin
        tick();
        checks++; if (pad_a !== (k == 0 ? 8'h00 : words[k-1])) begin errors++; $display("FAIL tx_hold[%0d] got=%h", k, pad_a); end
      end
      tx_valid = 1; tx_data = words[k];
      #1;
      checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL tx_ready[%0d] got=%b exp=1", k, tx_ready); end
      tick();
      checks++; if (pad_a !== words[k]) begin errors++; $display("FAIL tx_word[%0d] got=%h exp=%h", k, pad_a, words[k]); end
      checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL tx_model[%0d] got=%h exp=%h", k, obs, exp_vec()); end
    end
    tx_valid = 0;
    tick();
    checks++; if (pad_a !== 8'h04) begin errors++; $display("FAIL tx_hold_last got=%h exp=04", pad_a); end
    checks++; if ({pad_ds1, pad_ds0, pad_sr} !== cfg_at_turn) begin errors++; $display("FAIL cfg_outside_turn got=%b exp=%b", {pad_ds1, pad_ds0, pad_sr}, cfg_at_turn); end
  endtask

  task automatic test_drop_dir();
    int dead = 0;
    dir_req = 0; tx_valid = 1; tx_data = 8'hFF; pad_y = 8'h3C;
    #1;
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL drop_tx_ready got=%b exp=0", tx_ready); end
    tick();
    checks++; if (pad_oe !== 1'b0 || pad_a === 8'hFF) begin errors++; $display("FAIL drop_oe oe=%b a=%h exp oe=0 no ff", pad_oe, pad_a); end
    checks++; if ({pad_ds1, pad_ds0, pad_sr} !== {2'b10, ~cfg_at_turn[0]}) begin errors++; $display("FAIL cfg_next_turn got=%b", {pad_ds1, pad_ds0, pad_sr}); end
    if (busy === 1'b1) dead++;
    for (int i = 0; i < 8 && pad_ie !== 1'b1; i++) begin
      tick();
      if (busy === 1'b1) dead++;
      checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL drop_turn[%0d] got=%h exp=%h", i, obs, exp_vec()); end
    end
    checks++; if (pad_ie !== 1'b1 || dead != TURN) begin errors++; $display("FAIL drop_dead ie=%b dead=%0d exp ie=1 dead=%0d", pad_ie, dead, TURN); end
    tx_valid = 0;
    repeat (SYNC) tick();
    checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h3C) begin errors++; $display("FAIL rx_resume v=%b d=%h exp v=1 d=3c", rx_valid, rx_data); end
  endtask

  task automatic test_toggle();
    int oe_seen = 0, ie_seen = 0, busy_n = 0;
    dir_req = 1; tick(); dir_req = 0;
    for (int i = 0; i < 2 * TURN + 2; i++) begin
      if (busy === 1'b1) busy_n++;
      if (pad_oe === 1'b1) oe_seen++;
      tick();
      checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL abort_tx[%0d] got=%h exp=%h", i, obs, exp_vec()); end
    end
    checks++; if (oe_seen != 0 || busy_n != 2 * TURN || pad_ie !== 1'b1) begin errors++; $display("FAIL abort_tx_sum oe=%0d busy=%0d ie=%b exp 0/%0d/1", oe_seen, busy_n, pad_ie, 2 * TURN); end
    dir_req = 1;
    for (int i = 0; i < 10 && pad_oe !== 1'b1; i++) tick();
    checks++; if (pad_oe !== 1'b1) begin errors++; $display("FAIL reach_tx timeout oe=%b exp=1", pad_oe); end
    dir_req = 0; tick(); dir_req = 1;
    for (int i = 0; i < 12 && pad_oe !== 1'b1; i++) begin
      tick();
      if (pad_ie === 1'b1) ie_seen++;
      checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL abort_rx[%0d] got=%h exp=%h", i, obs, exp_vec()); end
    end
    checks++; if (pad_oe !== 1'b1 || ie_seen != 1) begin errors++; $display("FAIL abort_rx_sum oe=%b ie_cycles=%0d exp 1/1", pad_oe, ie_seen); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) dir_req = ~dir_req;
      tx_valid = 1'($urandom); tx_data = W'($urandom); pad_y = W'($urandom);
      cfg_ds = 2'($urandom); cfg_sr = 1'($urandom);
      #1;
      checks++; if (tx_ready !== (m_oe && dir_req)) begin errors++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", i, tx_ready, m_oe && dir_req); end
      tick();
      checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL rnd[%0d] got=%h exp=%h", i, obs, exp_vec()); end
    end
  endtask

  task automatic test_async_reset();
    dir_req = 1; tx_valid = 1; tx_data = 8'h5A; cfg_ds = 2'b11; cfg_sr = 1;
    for (int i = 0; i < 12 && pad_oe !== 1'b1; i++) tick();
    tick();
    checks++; if (pad_oe !== 1'b1 || pad_a !== 8'h5A) begin errors++; $display("FAIL pre_reset_tx oe=%b a=%h exp 1/5a", pad_oe, pad_a); end
    #2; rstn = 0; #1;
    model_reset();
    checks++; if (pad_oe !== 1'b0 || obs !== '0) begin errors++; $display("FAIL async_reset oe=%b obs=%h exp 0/0", pad_oe, obs); end
    dir_req = 0; tx_valid = 0;
    @(negedge clk); rstn = 1;
    tick();
    checks++; if (pad_ie !== 1'b1 || {pad_ds1, pad_ds0, pad_sr} !== 3'b000) begin errors++; $display("FAIL post_reset ie=%b cfg=%b exp 1/000", pad_ie, {pad_ds1, pad_ds0, pad_sr}); end
    checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL post_reset_model got=%h exp=%h", obs, exp_vec()); end
  endtask

  initial begin
    test_reset();
    test_rx_stream();
    test_turn_tx();
    test_tx_stream();
    test_drop_dir();
    test_toggle();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
